// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file geometry and writer state encoding
package regfile_pkg;

    localparam int RF_DEPTH  = 4096;
    localparam int RF_ADDR_W = 12;
    localparam int RF_CNT_W  = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/regfile_writer_fifo.sv
// rtl/regfile_writer_fifo.sv - skid FIFO between the upstream beat port and the register file
module regfile_writer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - frames upstream beats into register-file appends; REGFILE_WRITER_STATS_EN adds frame/error counters
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [RF_CNT_W-1:0]   frame_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [RF_CNT_W-1:0]   wr_count,
`ifdef REGFILE_WRITER_STATS_EN
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt,
`endif
    output logic                  full
);

    wr_state_e             state_q, state_d;
    logic [RF_CNT_W-1:0]   len_q, len_d;
    logic [RF_CNT_W-1:0]   beats_q, beats_d;
    logic [RF_CNT_W-1:0]   wr_count_q, wr_count_d;
    logic                  err_q, err_d;
    logic [RF_CNT_W-1:0]   room, beats_inc;
    logic                  accept, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    regfile_writer_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .wdata_i (s_data),
        .pop_i   (we),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign full      = (wr_count_q == RF_CNT_W'(RF_DEPTH));
    assign room      = RF_CNT_W'(RF_DEPTH) - wr_count_q;
    assign beats_inc = beats_q + RF_CNT_W'(1);
    assign s_ready   = (state_q == ST_LOAD) && !fifo_full && !full;
    assign accept    = s_valid && s_ready;
    assign we        = !fifo_empty;
    assign w_data    = we ? fifo_rdata : '0;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign wr_count  = wr_count_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beats_d = beats_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A frame that cannot fit in the remaining space is rejected whole.
                    if ((frame_len == '0) || (frame_len > room)) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        len_d   = frame_len;
                        beats_d = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    beats_d = beats_inc;
                    if ((beats_inc == len_q) || s_last) begin
                        // Error when s_last and the length count disagree.
                        err_d   = err_q | (s_last != (beats_inc == len_q));
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign wr_count_d = (we && !full) ? wr_count_q + RF_CNT_W'(1) : wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beats_q    <= '0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beats_q    <= beats_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

`ifdef REGFILE_WRITER_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (state_q == ST_DONE) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_q) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - self-checking bench for regfile_writer against a frame-level reference model
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] frame_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        we;
    logic [7:0]  w_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] wr_count;
    logic        full;
`ifdef REGFILE_WRITER_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`endif

    int ntests = 0;
    int nfail  = 0;
    int mdl_count  = 0;
    int mdl_frames = 0;
    int mdl_errs   = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    regfile_writer #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .frame_len (frame_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .we        (we),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wr_count  (wr_count),
`ifdef REGFILE_WRITER_STATS_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .full      (full)
    );

    always @(negedge clk) begin
        if (rst_n && we) got_q.push_back(w_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_w_data"}, w_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_wr_count"}, wr_count, 0);
        chk({tag, "_full"}, full, 0);
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk({tag, "_wdata"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // One frame: start pulse, then beats until the model says the frame ended.
    task automatic run_frame(input string tag, input int len, input int last_at,
                             input int gap_pct, input bit busy_start,
                             input bit fixed, input logic [7:0] d0);
        bit legal, exp_err, ended, r, seen;
        int i, guard;
        legal   = (len >= 1) && (len <= 4096 - mdl_count);
        exp_err = !legal;
        start = 1'b1;
        frame_len = len[12:0];
        step();
        start = 1'b0;
        if (legal) begin
            chk({tag, "_busy"}, busy, 1);
            i = 0;
            ended = 1'b0;
            guard = 0;
            while (!ended && guard < 20000) begin
                guard++;
                if ($urandom_range(99) < gap_pct) begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    s_data  = 8'($urandom);
                end else begin
                    s_valid = 1'b1;
                    s_data  = fixed ? d0 + i[7:0] : 8'($urandom);
                    s_last  = (i == last_at);
                end
                start = busy_start && (i == 1);
                frame_len = 13'd1;
                r = s_ready;
                step();
                start = 1'b0;
                if (s_valid && r) begin
                    exp_q.push_back(s_data);
                    chk({tag, "_we_after_accept"}, we, 1);
                    if (s_last || (i + 1 == len)) begin
                        ended   = 1'b1;
                        exp_err = (s_last != (i + 1 == len));
                    end
                    i++;
                end
            end
            chk({tag, "_frame_ended"}, ended, 1);
        end
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                chk({tag, "_ready_low"}, s_ready, 0);
                step();
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_at_done"}, busy, 0);
        step();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_idle"}, s_ready, 0);
        s_valid = 1'b0;
        mdl_count += exp_q.size();
        mdl_frames++;
        if (exp_err) mdl_errs++;
        compare_writes(tag);
        chk({tag, "_wr_count"}, wr_count, mdl_count);
        chk({tag, "_full"}, full, (mdl_count == 4096));
`ifdef REGFILE_WRITER_STATS_EN
        chk({tag, "_frame_cnt"}, frame_cnt, mdl_frames & 16'hFFFF);
        chk({tag, "_err_cnt"}, err_cnt, mdl_errs & 16'hFFFF);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, guard, len, la;
        bit r;
        rst_n = 1'b0;
        start = 1'b0;
        frame_len = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_frame("basic", 3, 2, 0, 1'b0, 1'b1, 8'hA1);
        run_frame("early_last", 4, 1, 0, 1'b0, 1'b1, 8'h10);
        run_frame("missing_last", 5, -1, 0, 1'b0, 1'b0, 8'h00);
        run_frame("busy_start", 6, 5, 0, 1'b1, 1'b0, 8'h00);
        run_frame("gaps64", 64, 63, 40, 1'b0, 1'b0, 8'h00);
        run_frame("zero_len", 0, -1, 0, 1'b0, 1'b0, 8'h00);
        run_frame("oversize", 4096, 4095, 0, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 4; n++) begin
            len = $urandom_range(1, 10);
            la  = $urandom_range(0, len);
            run_frame("rand", len, la, 30, 1'b0, 1'b0, 8'h00);
        end

        // Reset while beats are still buffered.
        start = 1'b1;
        frame_len = 13'd8;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_last = 1'b0;
        acc = 0;
        guard = 0;
        while (acc < 3 && guard < 50) begin
            guard++;
            s_data = 8'h50 + acc[7:0];
            r = s_ready;
            step();
            if (r) acc++;
        end
        chk("midreset_accepts", acc, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        got_q.delete();
        exp_q.delete();
        s_valid = 1'b0;
        mdl_count = 0;
        mdl_frames = 0;
        mdl_errs = 0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_reset_we", we, 0);
            chk("post_reset_wr_count", wr_count, 0);
        end
        chk("post_reset_nwrites", got_q.size(), 0);

        run_frame("fill", 4094, 4093, 0, 1'b0, 1'b0, 8'h00);
        run_frame("over_room", 3, 2, 0, 1'b0, 1'b0, 8'h00);
        run_frame("to_full", 2, 1, 0, 1'b0, 1'b1, 8'h77);
        run_frame("after_full", 1, 0, 0, 1'b0, 1'b0, 8'h00);
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("full_ready_low", s_ready, 0);
            chk("full_sticky", full, 1);
            step();
        end
        s_valid = 1'b0;
        chk("full_nwrites", got_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
